// File: rtl/keyb_matrix_scan.sv
// keyb_matrix_scan: 4x4 keypad scanner. Walks an active-low column drive, synchronises the rows,
// debounces press and release, and reports one key code plus a single key_valid pulse per press.
module keyb_matrix_scan #(
  parameter int COL_CYCLES = 1200,
  parameter int DB_CYCLES  = 12000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       btn_press
);

  localparam int MAX_CYCLES = (COL_CYCLES > DB_CYCLES) ? COL_CYCLES : DB_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COL_CYCLES - 1);
  localparam logic [CW-1:0] DB_LOAD  = CW'(DB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} stateT;

  stateT         r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_rowMeta;
  logic [3:0]    r_rowSync;
  logic [1:0]    r_keyCol;
  logic [1:0]    r_keyRow;
  logic [3:0]    r_colOut;
  logic [3:0]    r_keyCode;
  logic          r_keyValid;
  logic          r_btnPress;

  logic [1:0]    w_lowRow;
  logic          w_anyLow;
  logic          w_rowHigh;

  function automatic logic [3:0] colDrive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Lowest-index low row wins when several rows are pulled down together.
  always_comb begin
    casez (r_rowSync)
      4'b???0: w_lowRow = 2'd0;
      4'b??01: w_lowRow = 2'd1;
      4'b?011: w_lowRow = 2'd2;
      default: w_lowRow = 2'd3;
    endcase
  end

  assign w_anyLow  = ~&r_rowSync;
  assign w_rowHigh = r_rowSync[r_keyRow];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= SCAN;
      r_cnt      <= '0;
      r_rowMeta  <= 4'hF;
      r_rowSync  <= 4'hF;
      r_keyCol   <= 2'd0;
      r_keyRow   <= 2'd0;
      r_colOut   <= 4'b1110;
      r_keyCode  <= 4'h0;
      r_keyValid <= 1'b0;
      r_btnPress <= 1'b0;
    end else begin
      r_rowMeta  <= row_in;
      r_rowSync  <= r_rowMeta;
      r_keyValid <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_cnt == COL_LAST) begin
            if (w_anyLow) begin
              r_keyRow <= w_lowRow;
              r_cnt    <= DB_LOAD;
              r_state  <= DEBOUNCE;
            end else begin
              r_keyCol <= r_keyCol + 2'd1;
              r_colOut <= colDrive(r_keyCol + 2'd1);
              r_cnt    <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        DEBOUNCE: begin
          // A single high sample drops the candidate; the same column is re-dwelt from scratch.
          if (w_rowHigh) begin
            r_cnt   <= '0;
            r_state <= SCAN;
          end else if (r_cnt == CNT_ONE) begin
            r_keyCode  <= {r_keyRow, r_keyCol};
            r_keyValid <= 1'b1;
            r_btnPress <= 1'b1;
            r_cnt      <= DB_LOAD;
            r_state    <= HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        HOLD: begin
          if (!w_rowHigh) begin
            r_cnt <= DB_LOAD;
          end else if (r_cnt == CNT_ONE) begin
            r_btnPress <= 1'b0;
            r_keyCol   <= 2'd0;
            r_colOut   <= 4'b1110;
            r_cnt      <= '0;
            r_state    <= SCAN;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= SCAN;
        end
      endcase
    end
  end

  assign col_out   = r_colOut;
  assign key_code  = r_keyCode;
  assign key_valid = r_keyValid;
  assign btn_press = r_btnPress;

endmodule

// File: tb/tb_keyb_matrix_scan.sv
// Bench for keyb_matrix_scan: a simulated 4x4 keypad answers the column drive, and a run-length
// reference model predicts every output cycle by cycle.
module tb_keyb_matrix_scan;

  localparam int COL = 8;
  localparam int DB  = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       btn_press;

  logic [3:0] keyDown [4];

  int nChecks = 0;
  int nFail   = 0;

  keyb_matrix_scan #(.COL_CYCLES(COL), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .btn_press (btn_press)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keyDown[r][c] && !col_out[c]) row_in[r] = 1'b0;
  end

  int         mMode = 0;
  int         mDwell = 0;
  int         mRun = 0;
  int         mHigh = 0;
  int         mColIdx = 0;
  int         mRowIdx = 0;
  logic [3:0] mPipe1 = 4'hF;
  logic [3:0] mPipe2 = 4'hF;
  logic [3:0] mSeen = 4'hF;
  logic [3:0] expCol = 4'b1110;
  logic [3:0] expCode = 4'h0;
  logic       expValid = 1'b0;
  logic       expBtn = 1'b0;

  // Reference model: modes 0=scanning, 1=qualifying a press, 2=waiting for a clean release.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mMode = 0; mDwell = 0; mRun = 0; mHigh = 0; mColIdx = 0; mRowIdx = 0;
        mPipe1 = 4'hF; mPipe2 = 4'hF;
        expCol = 4'b1110; expCode = 4'h0; expValid = 1'b0; expBtn = 1'b0;
      end else begin
        mSeen  = mPipe2;
        mPipe2 = mPipe1;
        mPipe1 = row_in;
        expValid = 1'b0;
        if (mMode == 0) begin
          mDwell++;
          if (mDwell == COL) begin
            mDwell = 0;
            if (mSeen != 4'hF) begin
              for (int i = 3; i >= 0; i--) if (!mSeen[i]) mRowIdx = i;
              mRun  = 1;
              mMode = 1;
            end else begin
              mColIdx = (mColIdx + 1) % 4;
            end
          end
        end else if (mMode == 1) begin
          if (!mSeen[mRowIdx]) begin
            mRun++;
            if (mRun == DB + 1) begin
              expValid = 1'b1;
              expBtn   = 1'b1;
              expCode  = 4'(mRowIdx * 4 + mColIdx);
              mMode    = 2;
              mHigh    = 0;
            end
          end else begin
            mMode  = 0;
            mDwell = 0;
          end
        end else begin
          if (mSeen[mRowIdx]) mHigh++;
          else mHigh = 0;
          if (mHigh == DB) begin
            expBtn  = 1'b0;
            mColIdx = 0;
            mMode   = 0;
            mDwell  = 0;
          end
        end
        expCol = ~(4'b0001 << mColIdx);
      end
    end
  end

  logic [9:0] dutObs;
  logic [9:0] modelObs;
  assign dutObs   = {col_out, key_code, key_valid, btn_press};
  assign modelObs = {expCol, expCode, expValid, expBtn};

  task automatic clearKeys();
    for (int r = 0; r < 4; r++) keyDown[r] = 4'h0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clearKeys();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++;
    if (dutObs !== 10'b1110_0000_0_0) begin
      nFail++;
      $display("[TB] FAIL reset_values: got %b want %b", dutObs, 10'b1110_0000_0_0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [3:0] want;
    int pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      want = ~(4'b0001 << ((i / COL) % 4));
      nChecks++;
      if (col_out !== want) begin
        nFail++;
        $display("[TB] FAIL idle_col cyc %0d: got %b want %b", i, col_out, want);
      end
      nChecks++;
      if (dutObs !== modelObs) begin
        nFail++;
        $display("[TB] FAIL idle_model cyc %0d: got %b want %b", i, dutObs, modelObs);
      end
      if (key_valid === 1'b1) pulses++;
    end
    nChecks++;
    if (pulses != 0) begin
      nFail++;
      $display("[TB] FAIL idle_no_valid: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    int fall = 0;
    bit got = 0;
    clearKeys();
    doReset();
    keyDown[1][2] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      nChecks++;
      if (dutObs !== modelObs) begin
        nFail++;
        $display("[TB] FAIL clean_press_model: got %b want %b", dutObs, modelObs);
      end
      if (key_valid === 1'b1) begin pulses++; got = 1; end
    end
    nChecks++;
    if (!got) begin
      nFail++;
      $display("[TB] FAIL clean_press_timeout: got no key_valid want one within 200 cycles");
    end
    nChecks++;
    if (key_code !== 4'b0110 || btn_press !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL clean_press_code: got code %b btn %b want code 0110 btn 1", key_code, btn_press);
    end
    repeat (15) begin
      @(negedge clk);
      nChecks++;
      if (dutObs !== modelObs) begin
        nFail++;
        $display("[TB] FAIL clean_hold_model: got %b want %b", dutObs, modelObs);
      end
      if (key_valid === 1'b1) pulses++;
    end
    keyDown[1][2] = 1'b0;
    for (int i = 1; i <= 100 && fall == 0; i++) begin
      @(negedge clk);
      nChecks++;
      if (dutObs !== modelObs) begin
        nFail++;
        $display("[TB] FAIL clean_release_model: got %b want %b", dutObs, modelObs);
      end
      if (key_valid === 1'b1) pulses++;
      if (btn_press === 1'b0) fall = i;
    end
    nChecks++;
    if (fall != DB + 2) begin
      nFail++;
      $display("[TB] FAIL clean_release_delay: got %0d cycles want %0d", fall, DB + 2);
    end
    nChecks++;
    if (pulses != 1) begin
      nFail++;
      $display("[TB] FAIL clean_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_glitch_press();
    int r, c, down, elapsed, stable, fall;
    int pulses = 0;
    bit got = 0;
    logic [3:0] want;
    r = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    want = 4'(r * 4 + c);
    clearKeys();
    doReset();
    elapsed = 0;
    while (elapsed < 50) begin
      down = $urandom_range(3, 12);
      keyDown[r][c] = 1'b1;
      repeat (down) begin
        @(negedge clk);
        elapsed++;
        nChecks++;
        if (dutObs !== modelObs) begin
          nFail++;
          $display("[TB] FAIL glitch_model: got %b want %b", dutObs, modelObs);
        end
        if (key_valid === 1'b1) pulses++;
      end
      keyDown[r][c] = 1'b0;
      repeat (5) begin
        @(negedge clk);
        elapsed++;
        nChecks++;
        if (dutObs !== modelObs) begin
          nFail++;
          $display("[TB] FAIL glitch_gap_model: got %b want %b", dutObs, modelObs);
        end
        if (key_valid === 1'b1) pulses++;
      end
    end
    nChecks++;
    if (pulses != 0) begin
      nFail++;
      $display("[TB] FAIL glitch_early_valid: got %0d pulses want 0", pulses);
    end
    keyDown[r][c] = 1'b1;
    stable = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      stable++;
      nChecks++;
      if (dutObs !== modelObs) begin
        nFail++;
        $display("[TB] FAIL glitch_stable_model: got %b want %b", dutObs, modelObs);
      end
      if (key_valid === 1'b1) begin pulses++; got = 1; end
    end
    nChecks++;
    if (!got || stable < DB) begin
      nFail++;
      $display("[TB] FAIL glitch_accept: got valid %0d after %0d stable cycles want valid after >= %0d", got, stable, DB);
    end
    nChecks++;
    if (key_code !== want) begin
      nFail++;
      $display("[TB] FAIL glitch_code: got %b want %b", key_code, want);
    end
    keyDown[r][c] = 1'b0;
    fall = 0;
    for (int i = 1; i <= 100 && fall == 0; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) pulses++;
      if (btn_press === 1'b0) fall = i;
    end
    nChecks++;
    if (pulses != 1 || fall == 0) begin
      nFail++;
      $display("[TB] FAIL glitch_pulse_count: got %0d pulses fall %0d want 1 pulse and a release", pulses, fall);
    end
  endtask

  task automatic test_release_bounce();
    int r, c, fall;
    int pulses = 0;
    bit got = 0;
    r = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    clearKeys();
    doReset();
    keyDown[r][c] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin pulses++; got = 1; end
    end
    nChecks++;
    if (!got) begin
      nFail++;
      $display("[TB] FAIL bounce_press_timeout: got no key_valid want one within 200 cycles");
    end
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      keyDown[r][c] = 1'b0;
      repeat (10) begin
        @(negedge clk);
        nChecks++;
        if (btn_press !== 1'b1 || dutObs !== modelObs) begin
          nFail++;
          $display("[TB] FAIL bounce_high: got %b want %b with btn 1", dutObs, modelObs);
        end
        if (key_valid === 1'b1) pulses++;
      end
      keyDown[r][c] = 1'b1;
      repeat (3) begin
        @(negedge clk);
        nChecks++;
        if (btn_press !== 1'b1 || dutObs !== modelObs) begin
          nFail++;
          $display("[TB] FAIL bounce_low: got %b want %b with btn 1", dutObs, modelObs);
        end
        if (key_valid === 1'b1) pulses++;
      end
    end
    keyDown[r][c] = 1'b0;
    fall = 0;
    for (int i = 1; i <= 100 && fall == 0; i++) begin
      @(negedge clk);
      nChecks++;
      if (dutObs !== modelObs) begin
        nFail++;
        $display("[TB] FAIL bounce_release_model: got %b want %b", dutObs, modelObs);
      end
      if (key_valid === 1'b1) pulses++;
      if (btn_press === 1'b0) fall = i;
    end
    nChecks++;
    if (fall != DB + 2) begin
      nFail++;
      $display("[TB] FAIL bounce_release_delay: got %0d cycles want %0d", fall, DB + 2);
    end
    nChecks++;
    if (pulses != 1) begin
      nFail++;
      $display("[TB] FAIL bounce_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_multi_key();
    int pulses = 0;
    int fall = 0;
    bit got = 0;
    clearKeys();
    doReset();
    keyDown[0][1] = 1'b1;
    keyDown[3][1] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      nChecks++;
      if (dutObs !== modelObs) begin
        nFail++;
        $display("[TB] FAIL multi_press_model: got %b want %b", dutObs, modelObs);
      end
      if (key_valid === 1'b1) begin pulses++; got = 1; end
    end
    nChecks++;
    if (!got || key_code !== 4'b0001) begin
      nFail++;
      $display("[TB] FAIL multi_code: got valid %0d code %b want valid 1 code 0001", got, key_code);
    end
    keyDown[2][3] = 1'b1;
    repeat (60) begin
      @(negedge clk);
      nChecks++;
      if (dutObs !== modelObs) begin
        nFail++;
        $display("[TB] FAIL multi_hold_model: got %b want %b", dutObs, modelObs);
      end
      if (key_valid === 1'b1) pulses++;
    end
    nChecks++;
    if (pulses != 1 || key_code !== 4'b0001 || btn_press !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL multi_ignore: got %0d pulses code %b btn %b want 1 0001 1", pulses, key_code, btn_press);
    end
    clearKeys();
    for (int i = 1; i <= 100 && fall == 0; i++) begin
      @(negedge clk);
      if (btn_press === 1'b0) fall = i;
    end
    nChecks++;
    if (fall != DB + 2) begin
      nFail++;
      $display("[TB] FAIL multi_release_delay: got %0d cycles want %0d", fall, DB + 2);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    bit got;
    clearKeys();
    doReset();
    keyDown[2][0] = 1'b1;
    repeat (15) begin
      @(negedge clk);
      nChecks++;
      if (dutObs !== modelObs) begin
        nFail++;
        $display("[TB] FAIL mid_debounce_model: got %b want %b", dutObs, modelObs);
      end
      if (key_valid === 1'b1) pulses++;
    end
    reset_n = 1'b0;
    #1;
    nChecks++;
    if (dutObs !== 10'b1110_0000_0_0 || pulses != 0) begin
      nFail++;
      $display("[TB] FAIL reset_in_debounce: got %b pulses %0d want 1110000000 pulses 0", dutObs, pulses);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      got = 0;
      pulses = 0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        nChecks++;
        if (dutObs !== modelObs) begin
          nFail++;
          $display("[TB] FAIL redetect_model phase %0d: got %b want %b", phase, dutObs, modelObs);
        end
        if (key_valid === 1'b1) begin pulses++; got = 1; end
      end
      nChecks++;
      if (!got || key_code !== 4'b1000 || btn_press !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL redetect phase %0d: got valid %0d code %b btn %b want 1 1000 1", phase, got, key_code, btn_press);
      end
      repeat (10) begin
        @(negedge clk);
        if (key_valid === 1'b1) pulses++;
      end
      nChecks++;
      if (pulses != 1) begin
        nFail++;
        $display("[TB] FAIL redetect_pulses phase %0d: got %0d want 1", phase, pulses);
      end
      if (phase == 0) begin
        reset_n = 1'b0;
        #1;
        nChecks++;
        if (dutObs !== 10'b1110_0000_0_0) begin
          nFail++;
          $display("[TB] FAIL reset_in_hold: got %b want %b", dutObs, 10'b1110_0000_0_0);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
      end
    end
    clearKeys();
    repeat (40) @(negedge clk);
    nChecks++;
    if (btn_press !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_mid_release: got btn %b want 0", btn_press);
    end
  endtask

  task automatic test_random();
    int r, c;
    clearKeys();
    doReset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      nChecks++;
      if (dutObs !== modelObs) begin
        nFail++;
        $display("[TB] FAIL random_model cyc %0d: got %b want %b", i, dutObs, modelObs);
      end
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        keyDown[r][c] = ~keyDown[r][c];
      end
      if ($urandom_range(0, 199) == 0) clearKeys();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    clearKeys();
    $display("[TB] starting keyb_matrix_scan bench");
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_glitch_press();
    test_release_bounce();
    test_multi_key();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
